// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration-time helpers for the raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_H_VALID = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_V_VALID = 480;
    localparam int DEF_V_FRONT = 10;

    function automatic int axis_total(input int sync, input int back, input int valid, input int front);
        return sync + back + valid + front;
    endfunction

    // The request window must stay inside the line, and both counters must fit CNT_W bits.
    function automatic bit params_ok(input int h_total, input int v_total, input int req_lead,
                                     input int h_back, input int cnt_w);
        return (req_lead >= 1) && (req_lead <= h_back) &&
               (h_total <= (1 << cnt_w)) && (v_total <= (1 << cnt_w));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source request/response and video output bundle of the timing generator.
interface vga_timing_gen_if #(
    parameter int CNT_W  = 12,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_req;
    logic [CNT_W-1:0]  pix_x;
    logic [CNT_W-1:0]  pix_y;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [DATA_W-1:0] rgb;
    logic              frame_start;
    logic              line_start;

    modport master (
        input  pix_data,
        output pix_req, pix_x, pix_y, hsync, vsync, de, rgb, frame_start, line_start
    );

    modport slave (
        output pix_data,
        input  pix_req, pix_x, pix_y, hsync, vsync, de, rgb, frame_start, line_start
    );
endinterface

// File: rtl/vga_axis_cnt.sv
// Wrapping 0..TOTAL-1 counter for one raster axis; tc flags the last count so
// the next axis can use it as its enable.
module vga_axis_cnt #(
    parameter int TOTAL = 800,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (en) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data enable, pixel coordinate requests
// with a configurable lead, gated pixel output and frame/line strobes, all registered.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_VALID  = DEF_H_VALID,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_VALID  = DEF_V_VALID,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int REQ_LEAD = 1,
    parameter int CNT_W    = 12,
    parameter int DATA_W   = 16
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    vga_timing_gen_if.master vid
);
    localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_VALID, H_FRONT);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_VALID, V_FRONT);
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    // Inclusive window bounds keep every constant representable in CNT_W bits.
    localparam logic [CNT_W-1:0] H_SYNC_C    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] HA_C        = CNT_W'(HA);
    localparam logic [CNT_W-1:0] HA_LAST_C   = CNT_W'(HA + H_VALID - 1);
    localparam logic [CNT_W-1:0] REQ_FIRST_C = CNT_W'(HA - REQ_LEAD);
    localparam logic [CNT_W-1:0] REQ_LAST_C  = CNT_W'(HA - REQ_LEAD + H_VALID - 1);
    localparam logic [CNT_W-1:0] V_SYNC_C    = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] VA_C        = CNT_W'(VA);
    localparam logic [CNT_W-1:0] VA_LAST_C   = CNT_W'(VA + V_VALID - 1);

    if (!params_ok(H_TOTAL, V_TOTAL, REQ_LEAD, H_BACK, CNT_W)) begin : g_bad_params
        $error("vga_timing_gen: REQ_LEAD must be 1..H_BACK and CNT_W must hold H_TOTAL-1 and V_TOTAL-1");
    end

    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       tc;
    logic [1:0]       en;
    logic [CNT_W-1:0] cnt_h;
    logic [CNT_W-1:0] cnt_v;
    logic             unused_frame_end;

    // Axis 0 is horizontal and free-running; axis 1 steps on the last clock of each line.
    assign en = {tc[0], 1'b1};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_axis
        vga_axis_cnt #(
            .TOTAL (gi == 0 ? H_TOTAL : V_TOTAL),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk  (vga_clk),
            .srst (sys_rst),
            .en   (en[gi]),
            .cnt  (cnt[gi]),
            .tc   (tc[gi])
        );
    end

    assign cnt_h            = cnt[0];
    assign cnt_v            = cnt[1];
    assign unused_frame_end = tc[1];

    logic              v_active;
    logic              active;
    logic              req;
    logic              hsync_next, vsync_next, de_next, req_next;
    logic              line_start_next, frame_start_next;
    logic [CNT_W-1:0]  pix_x_next, pix_y_next;
    logic [DATA_W-1:0] rgb_next;

    always_comb begin
        v_active         = (cnt_v >= VA_C) && (cnt_v <= VA_LAST_C);
        active           = v_active && (cnt_h >= HA_C) && (cnt_h <= HA_LAST_C);
        req              = v_active && (cnt_h >= REQ_FIRST_C) && (cnt_h <= REQ_LAST_C);
        hsync_next       = (cnt_h < H_SYNC_C) ? HS_POL : ~HS_POL;
        vsync_next       = (cnt_v < V_SYNC_C) ? VS_POL : ~VS_POL;
        de_next          = active;
        req_next         = req;
        pix_x_next       = req ? (cnt_h - REQ_FIRST_C) : '1;
        pix_y_next       = req ? (cnt_v - VA_C) : '1;
        rgb_next         = active ? vid.pix_data : '0;
        line_start_next  = (cnt_h == '0);
        frame_start_next = (cnt_h == '0) && (cnt_v == '0);
    end

    logic              hsync_reg, vsync_reg, de_reg, req_reg;
    logic              line_start_reg, frame_start_reg;
    logic [CNT_W-1:0]  pix_x_reg, pix_y_reg;
    logic [DATA_W-1:0] rgb_reg;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            de_reg          <= 1'b0;
            req_reg         <= 1'b0;
            pix_x_reg       <= '1;
            pix_y_reg       <= '1;
            rgb_reg         <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            de_reg          <= de_next;
            req_reg         <= req_next;
            pix_x_reg       <= pix_x_next;
            pix_y_reg       <= pix_y_next;
            rgb_reg         <= rgb_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign vid.hsync       = hsync_reg;
    assign vid.vsync       = vsync_reg;
    assign vid.de          = de_reg;
    assign vid.pix_req     = req_reg;
    assign vid.pix_x       = pix_x_reg;
    assign vid.pix_y       = pix_y_reg;
    assign vid.rgb         = rgb_reg;
    assign vid.line_start  = line_start_reg;
    assign vid.frame_start = frame_start_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes run side by side against a linear-time
// raster model (outputs derived from the number of clocks since reset).
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic        req;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] rgb;
        logic        fs;
        logic        ls;
    } sig_t;

    typedef struct {
        int hs, hb, hv, hf, vs, vb, vv, vf;
        bit hpol, vpol;
        int lead, cw, src;
    } mode_t;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    int         vectors = 0;
    int         miscompares = 0;
    int         n [3];
    int         seed = 0;
    mode_t      modes [3];
    sig_t       obs [3];

    always #5 clk = ~clk;

    // Clocks since the last reset edge, per DUT.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) n[d] <= rst[d] ? 0 : n[d] + 1;
    end

    function automatic logic [15:0] src(input int kind, input int x, input int y, input int sd);
        if (kind == 0) return 16'(x);
        return 16'((x * 37 + y * 11) ^ sd);
    endfunction

    // Expected outputs after n clocks since reset, from the raster rules alone.
    function automatic sig_t model(input mode_t m, input int cyc);
        sig_t s;
        int ht, vt, p, h, v, ha, va;
        bit vin;
        logic [15:0] ones;
        ones = 16'((1 << m.cw) - 1);
        if (cyc == 0) begin
            s = '{hsync: ~m.hpol, vsync: ~m.vpol, de: 1'b0, req: 1'b0, x: ones, y: ones,
                  rgb: 16'h0, fs: 1'b0, ls: 1'b0};
            return s;
        end
        ht  = m.hs + m.hb + m.hv + m.hf;
        vt  = m.vs + m.vb + m.vv + m.vf;
        ha  = m.hs + m.hb;
        va  = m.vs + m.vb;
        p   = (cyc - 1) % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        vin = (v >= va) && (v < va + m.vv);
        s.hsync = (h < m.hs) ? m.hpol : ~m.hpol;
        s.vsync = (v < m.vs) ? m.vpol : ~m.vpol;
        s.de    = vin && (h >= ha) && (h < ha + m.hv);
        s.req   = vin && (h >= ha - m.lead) && (h < ha - m.lead + m.hv);
        s.x     = s.req ? 16'(h - (ha - m.lead)) : ones;
        s.y     = s.req ? 16'(v - va) : ones;
        s.rgb   = s.de ? src(m.src, h - ha, v - va, seed) : 16'h0;
        s.ls    = (h == 0);
        s.fs    = (p == 0);
        return s;
    endfunction

    // DUT0: default 640x480, combinational source pix_data = pix_x
    vga_timing_gen_if #(.CNT_W(12), .DATA_W(16)) if0 ();
    vga_timing_gen u_dut0 (.vga_clk(clk), .sys_rst(rst[0]), .vid(if0));
    assign if0.pix_data = {4'b0, if0.pix_x};
    assign obs[0] = {if0.hsync, if0.vsync, if0.de, if0.pix_req, 4'b0, if0.pix_x, 4'b0, if0.pix_y,
                     if0.rgb, if0.frame_start, if0.line_start};

    // DUT1: small mode, negative syncs, lead 3 with a 2-register source pipeline
    vga_timing_gen_if #(.CNT_W(8), .DATA_W(16)) if1 ();
    vga_timing_gen #(
        .H_SYNC(8), .H_BACK(6), .H_VALID(20), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(3), .V_VALID(10), .V_FRONT(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(3), .CNT_W(8), .DATA_W(16)
    ) u_dut1 (.vga_clk(clk), .sys_rst(rst[1]), .vid(if1));
    logic [7:0] p1, p2;
    always @(posedge clk) begin
        p1 <= if1.pix_x;
        p2 <= p1;
    end
    assign if1.pix_data = {8'b0, p2};
    assign obs[1] = {if1.hsync, if1.vsync, if1.de, if1.pix_req, 8'b0, if1.pix_x, 8'b0, if1.pix_y,
                     if1.rgb, if1.frame_start, if1.line_start};

    // DUT2: tiny mode, lead 2 with a 1-register source of a seeded (x,y) hash
    vga_timing_gen_if #(.CNT_W(4), .DATA_W(16)) if2 ();
    vga_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_VALID(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(2), .CNT_W(4), .DATA_W(16)
    ) u_dut2 (.vga_clk(clk), .sys_rst(rst[2]), .vid(if2));
    logic [15:0] q1;
    always @(posedge clk) q1 <= src(1, int'(if2.pix_x), int'(if2.pix_y), seed);
    assign if2.pix_data = q1;
    assign obs[2] = {if2.hsync, if2.vsync, if2.de, if2.pix_req, 12'b0, if2.pix_x, 12'b0, if2.pix_y,
                     if2.rgb, if2.frame_start, if2.line_start};

    task automatic test_reset();
        sig_t e;
        rst = 3'b111;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            e = model(modes[d], 0);
            vectors++;
            if (obs[d] !== e) begin
                miscompares++;
                $display("FAIL reset_values dut%0d: got %h, want %h", d, obs[d], e);
            end
        end
        rst = 3'b000;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if ({obs[d].fs, obs[d].ls, obs[d].hsync, obs[d].vsync} !== {2'b11, modes[d].hpol, modes[d].vpol}) begin
                miscompares++;
                $display("FAIL first_cycle dut%0d: got fs/ls/hs/vs=%b%b%b%b, want 11%b%b", d,
                         obs[d].fs, obs[d].ls, obs[d].hsync, obs[d].vsync, modes[d].hpol, modes[d].vpol);
            end
        end
        $display("test_reset: reset values and first strobes checked on 3 modes");
    endtask

    task automatic test_default_mode();
        sig_t e;
        int hs_hi = 0;
        int first_de = -1;
        int de_cnt = 0;
        while (n[0] <= 36 * 800) begin
            e = model(modes[0], n[0]);
            vectors++;
            if (obs[0] !== e) begin
                miscompares++;
                $display("FAIL default_cycle n=%0d: got %h, want %h", n[0], obs[0], e);
            end
            if (n[0] >= 1 && n[0] <= 800 && obs[0].hsync) hs_hi++;
            if (obs[0].de) begin
                de_cnt++;
                if (first_de < 0) first_de = n[0];
            end
            @(negedge clk);
        end
        vectors++;
        if (hs_hi !== 96) begin
            miscompares++;
            $display("FAIL default_hsync_width: got %0d, want 96", hs_hi);
        end
        vectors++;
        if (first_de !== 35 * 800 + 145) begin
            miscompares++;
            $display("FAIL default_first_de: got clock %0d, want %0d", first_de, 35 * 800 + 145);
        end
        vectors++;
        if (de_cnt !== 640) begin
            miscompares++;
            $display("FAIL default_de_per_line: got %0d, want 640", de_cnt);
        end
        $display("test_default_mode: first 36 lines of 640x480 checked");
    endtask

    task automatic test_lead3_pol0();
        sig_t e;
        int hs_low = 0, vs_low = 0, de_cnt = 0, first_req = -1, first_de = -1;
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        while (n[1] <= 646) begin
            e = model(modes[1], n[1]);
            vectors++;
            if (obs[1] !== e) begin
                miscompares++;
                $display("FAIL lead3_cycle n=%0d: got %h, want %h", n[1], obs[1], e);
            end
            if (n[1] >= 1) begin
                if (n[1] <= 38 && !obs[1].hsync) hs_low++;
                if (!obs[1].vsync) vs_low++;
                if (obs[1].de) de_cnt++;
                if (obs[1].de && first_de < 0) first_de = n[1];
                if (obs[1].req && first_req < 0) first_req = n[1];
            end
            @(negedge clk);
        end
        vectors++;
        if (hs_low !== 8) begin
            miscompares++;
            $display("FAIL pol0_hsync_low: got %0d, want 8", hs_low);
        end
        vectors++;
        if (vs_low !== 2 * 38) begin
            miscompares++;
            $display("FAIL pol0_vsync_low: got %0d, want %0d", vs_low, 2 * 38);
        end
        vectors++;
        if (de_cnt !== 200) begin
            miscompares++;
            $display("FAIL lead3_de_per_frame: got %0d, want 200", de_cnt);
        end
        vectors++;
        if (first_de - first_req !== 3) begin
            miscompares++;
            $display("FAIL lead3_req_lead: got %0d, want 3", first_de - first_req);
        end
        $display("test_lead3_pol0: one frame of lead-3 negative-sync mode checked");
    endtask

    task automatic test_mid_reset();
        sig_t e;
        int k = 0;
        int guard = 0;
        while (!(n[1] > 0 && (n[1] % 646) == 8 * 38 + 30) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (guard >= 1000) begin
            miscompares++;
            $display("FAIL mid_reset_wait: got timeout, want counter position (30,8)");
        end
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        e = model(modes[1], 0);
        vectors++;
        if (obs[1] !== e) begin
            miscompares++;
            $display("FAIL mid_reset_values: got %h, want %h", obs[1], e);
        end
        @(negedge clk);
        vectors++;
        if (obs[1].fs !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_first_fs: got %b, want 1", obs[1].fs);
        end
        do begin
            @(negedge clk);
            k++;
        end while (obs[1].fs !== 1'b1 && k < 1000);
        vectors++;
        if (k !== 646) begin
            miscompares++;
            $display("FAIL mid_reset_frame_period: got %0d, want 646", k);
        end
        $display("test_mid_reset: reset at (30,8) and frame period checked");
    endtask

    task automatic test_tiny_random();
        sig_t e;
        int fs_cnt = 0;
        int wait_cyc, len;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        while (n[2] <= 180) begin
            e = model(modes[2], n[2]);
            vectors++;
            if (obs[2] !== e) begin
                miscompares++;
                $display("FAIL tiny_cycle n=%0d: got %h, want %h", n[2], obs[2], e);
            end
            if (obs[2].fs) fs_cnt++;
            @(negedge clk);
        end
        vectors++;
        if (fs_cnt !== 3) begin
            miscompares++;
            $display("FAIL tiny_frame_count: got %0d, want 3", fs_cnt);
        end
        for (int it = 0; it < 8; it++) begin
            wait_cyc = $urandom_range(1, 80);
            len      = $urandom_range(1, 3);
            repeat (wait_cyc) begin
                e = model(modes[2], n[2]);
                vectors++;
                if (obs[2] !== e) begin
                    miscompares++;
                    $display("FAIL tiny_rand_cycle n=%0d: got %h, want %h", n[2], obs[2], e);
                end
                @(negedge clk);
            end
            rst[2] = 1'b1;
            repeat (len) begin
                @(negedge clk);
                e = model(modes[2], 0);
                vectors++;
                if (obs[2] !== e) begin
                    miscompares++;
                    $display("FAIL tiny_rand_reset: got %h, want %h", obs[2], e);
                end
            end
            rst[2] = 1'b0;
            $display("test_tiny_random: reset %0d of 8 after %0d clocks for %0d clocks", it + 1, wait_cyc, len);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        modes[0] = '{96, 48, 640, 16, 2, 33, 480, 10, 1'b1, 1'b1, 1, 12, 0};
        modes[1] = '{8, 6, 20, 4, 2, 3, 10, 2, 1'b0, 1'b0, 3, 8, 0};
        modes[2] = '{2, 2, 4, 2, 1, 1, 3, 1, 1'b1, 1'b1, 2, 4, 1};
        seed = int'($urandom_range(0, 65535));
        test_reset();
        test_default_mode();
        test_lead3_pol0();
        test_mid_reset();
        test_tiny_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
